// File: rtl/tros_pkg.sv
// Shared definitions for the readout framer.
// Holds the frame-length helper, the default preamble, the channel ids of the
// three frequency counters plus the dummy channel, and the framer FSM states.
package tros_pkg;

  localparam logic [3:0] PREAMBLE_DEFAULT = 4'b1010;

  // Channel ids as carried in the frame header.
  localparam logic [1:0] CH_NAND4     = 2'd0;
  localparam logic [1:0] CH_NAND4_CAP = 2'd1;
  localparam logic [1:0] CH_EINV_SUB  = 2'd2;
  localparam logic [1:0] CH_DUMMY     = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Preamble (4) + channel id (2) + parity (1) around the counter value.
  function automatic int frame_len(input int counter_length);
    return counter_length + 7;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser with a rising-edge detector.
// Ports:
//   clk   : sampling clock
//   reset : asynchronous active-high reset, clears every flop
//   d     : asynchronous input level
//   q     : synchronised level (output of the last synchroniser flop)
//   rise  : one-cycle pulse when q goes 0 -> 1 (uses one extra edge flop)
module sync_edge #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [N-1:0] sync;
  logic         prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[N-2:0], d};
      prev <= sync[N-1];
    end
  end

  assign q    = sync[N-1];
  assign rise = sync[N-1] & ~prev;

endmodule

// File: rtl/readout_framer.sv
// Serial readout framer for the three frequency-measurement counters.
// On an accepted send request it snapshots the counter(s) and shifts out
// frames of PREAMBLE, channel id, counter value and even parity, MSB first,
// one bit cell per clk. The line is Manchester coded as shift MSB XOR clk.
// Ports:
//   clk         : readout clock from the RP2040
//   reset       : asynchronous active-high reset
//   ena         : design enable (3-flop synchronised)
//   send_req    : request level (2-flop synchronised + edge flop)
//   sweep_all   : 1 = send channels 0,1,2 back-to-back, sampled at accept
//   ch_select   : channel for single mode, 3 = dummy channel (count 0)
//   count0..2   : latched counter values
//   data_stream : Manchester line
//   busy        : high while frames are being shifted
//   frame_done  : one-cycle pulse after the last bit of each frame
module readout_framer
  import tros_pkg::*;
#(
  parameter int         COUNTER_LENGTH = 20,
  parameter logic [3:0] PREAMBLE       = PREAMBLE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ena,
  input  logic                      send_req,
  input  logic                      sweep_all,
  input  logic [1:0]                ch_select,
  input  logic [COUNTER_LENGTH-1:0] count0,
  input  logic [COUNTER_LENGTH-1:0] count1,
  input  logic [COUNTER_LENGTH-1:0] count2,
  output logic                      data_stream,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int FL    = frame_len(COUNTER_LENGTH);
  localparam int CNT_W = $clog2(FL);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FL - 1);

  logic ena_sync, unused_ena_rise;
  logic unused_req_level, req_rise;

  sync_edge #(.N(3)) u_ena_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ena),
    .q     (ena_sync),
    .rise  (unused_ena_rise)
  );

  sync_edge #(.N(2)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (send_req),
    .q     (unused_req_level),
    .rise  (req_rise)
  );

  state_t                    state, state_n;
  logic [FL-1:0]             shift_reg, shift_n;
  logic [CNT_W-1:0]          bitcnt, bitcnt_n;
  logic [1:0]                ch, ch_n;
  logic                      sweep, sweep_n;
  logic                      done_n;
  logic                      snap_en;
  logic [COUNTER_LENGTH-1:0] snap0, snap1, snap2;

  function automatic logic [COUNTER_LENGTH-1:0] sel_count(
    input logic [1:0]                c,
    input logic [COUNTER_LENGTH-1:0] a,
    input logic [COUNTER_LENGTH-1:0] b,
    input logic [COUNTER_LENGTH-1:0] d
  );
    case (c)
      CH_NAND4:     return a;
      CH_NAND4_CAP: return b;
      CH_EINV_SUB:  return d;
      default:      return '0;
    endcase
  endfunction

  // Parity makes the 1-count over channel id, value and parity even.
  function automatic logic [FL-1:0] build_frame(
    input logic [1:0]                c,
    input logic [COUNTER_LENGTH-1:0] v
  );
    return {PREAMBLE, c, v, ^{c, v}};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bitcnt     <= '0;
      ch         <= '0;
      sweep      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shift_reg  <= shift_n;
      bitcnt     <= bitcnt_n;
      ch         <= ch_n;
      sweep      <= sweep_n;
      frame_done <= done_n;
    end
  end

  // All three counters are captured together so a sweep reports one instant.
  always_ff @(posedge clk) begin
    if (snap_en) begin
      snap0 <= count0;
      snap1 <= count1;
      snap2 <= count2;
    end
  end

  always_comb begin
    state_n  = state;
    shift_n  = {shift_reg[FL-2:0], 1'b0};
    bitcnt_n = bitcnt;
    ch_n     = ch;
    sweep_n  = sweep;
    done_n   = 1'b0;
    snap_en  = 1'b0;
    case (state)
      IDLE: begin
        if (req_rise && ena_sync) begin
          snap_en  = 1'b1;
          sweep_n  = sweep_all;
          ch_n     = sweep_all ? CH_NAND4 : ch_select;
          shift_n  = build_frame(ch_n, sel_count(ch_n, count0, count1, count2));
          bitcnt_n = LAST_IDX;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (bitcnt == '0) begin
          done_n = 1'b1;
          if (sweep && (ch < CH_EINV_SUB)) begin
            // Next sweep frame starts on the very next cell, no gap.
            ch_n     = ch + 2'd1;
            shift_n  = build_frame(ch_n, sel_count(ch_n, snap0, snap1, snap2));
            bitcnt_n = LAST_IDX;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bitcnt_n = bitcnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy        = (state == SHIFT);
  assign data_stream = shift_reg[FL-1] ^ clk;

endmodule

// File: tb/tb_readout_framer.sv
module tb_readout_framer;

  localparam int CL = 20;
  localparam int FL = CL + 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ena = 1'b1;
  logic          send_req = 1'b0;
  logic          sweep_all = 1'b0;
  logic [1:0]    ch_select = 2'd0;
  logic [CL-1:0] count0 = '0, count1 = '0, count2 = '0;
  logic          data_stream, busy, frame_done;

  int checks = 0;
  int failures = 0;

  logic [FL-1:0] exp_q[$];
  int            burst_q[$];

  readout_framer #(.COUNTER_LENGTH(CL)) dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .send_req    (send_req),
    .sweep_all   (sweep_all),
    .ch_select   (ch_select),
    .count0      (count0),
    .count1      (count1),
    .count2      (count2),
    .data_stream (data_stream),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: header, channel, value (dummy channel carries zero), then a
  // parity bit chosen so the number of ones after the preamble is even.
  function automatic logic [FL-1:0] exp_frame(input logic [1:0] ch, input logic [CL-1:0] cnt);
    logic [CL-1:0] v;
    int ones;
    v = (ch == 2'd3) ? '0 : cnt;
    ones = $countones({ch, v});
    return {4'b1010, ch, v, (ones % 2 == 1) ? 1'b1 : 1'b0};
  endfunction

  // Monitor: decodes the line at the low clock phase, where data_stream
  // equals the transmitted bit, and checks frames, frame_done and burst length.
  int            nbits = 0;
  int            run = 0;
  bit            done_pend = 0;
  logic [FL-1:0] bits = '0;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      nbits = 0;
      run = 0;
      done_pend = 0;
    end else begin
      if (done_pend || frame_done) check("frame_done", 64'(frame_done), 64'(done_pend));
      done_pend = 0;
      if (busy) begin
        bits = {bits[FL-2:0], data_stream};
        nbits++;
        run++;
        if (nbits == FL) begin
          nbits = 0;
          done_pend = 1;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'(bits), 64'h0);
            if (bits === '0) check("unexpected_frame_flag", 64'd1, 64'd0);
          end else begin
            check("frame_bits", 64'(bits), 64'(exp_q.pop_front()));
          end
        end
      end else if (run > 0) begin
        if (burst_q.size() == 0) check("unexpected_burst", 64'(run), 64'd0);
        else check("busy_cycles", 64'(run), 64'(burst_q.pop_front()));
        run = 0;
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 400) begin
      @(posedge clk); #1;
      i++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Issue one accepted request and verify its start latency. Optionally
  // send a second edge while busy, or drop ena once the frame has started.
  task automatic do_req(input bit sw, input logic [1:0] ch,
                        input logic [CL-1:0] c0, input logic [CL-1:0] c1, input logic [CL-1:0] c2,
                        input bit second_edge, input bit drop_ena);
    @(posedge clk); #1;
    sweep_all = sw;
    ch_select = ch;
    count0 = c0; count1 = c1; count2 = c2;
    if (sw) begin
      exp_q.push_back(exp_frame(2'd0, c0));
      exp_q.push_back(exp_frame(2'd1, c1));
      exp_q.push_back(exp_frame(2'd2, c2));
      burst_q.push_back(3 * FL);
    end else begin
      exp_q.push_back(exp_frame(ch, (ch == 2'd0) ? c0 : (ch == 2'd1) ? c1 : c2));
      burst_q.push_back(FL);
    end
    send_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("busy_before_accept", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("busy_at_accept", 64'(busy), 64'd1);
    check("first_cell_line", 64'(data_stream), 64'd0);
    @(posedge clk); #1;
    send_req = 1'b0;
    if (drop_ena) ena = 1'b0;
    count0 = $urandom; count1 = $urandom; count2 = $urandom;
    sweep_all = $urandom;
    ch_select = $urandom;
    if (second_edge) begin
      repeat (4) @(posedge clk);
      #1 send_req = 1'b1;
      repeat (3) @(posedge clk);
      #1 send_req = 1'b0;
    end
    wait_idle();
    if (drop_ena) begin
      ena = 1'b1;
      repeat (6) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit saw_busy;
    // Reset state
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_line_low", 64'(data_stream), 64'(clk));
    #5;
    check("reset_line_high", 64'(data_stream), 64'(clk));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("idle_line", 64'(data_stream), 64'(clk));

    // Directed frames
    do_req(1'b0, 2'd0, 20'h00003, 20'h0, 20'h0, 1'b0, 1'b0);
    do_req(1'b0, 2'd1, 20'h0, 20'h00001, 20'h0, 1'b0, 1'b0);
    do_req(1'b0, 2'd1, 20'h0, 20'h00000, 20'h0, 1'b0, 1'b0);
    do_req(1'b1, 2'd0, 20'hABCDE, 20'h12345, 20'hFFFFF, 1'b0, 1'b0);
    do_req(1'b0, 2'd3, 20'hFFFFF, 20'h55555, 20'hAAAAA, 1'b0, 1'b0);
    do_req(1'b0, 2'd2, 20'h80001, 20'h0, 20'h7F00F, 1'b1, 1'b0);
    do_req(1'b1, 2'd0, 20'h11111, 20'h22222, 20'h33333, 1'b0, 1'b1);

    // ena low: request must be dropped
    ena = 1'b0;
    repeat (6) @(posedge clk);
    #1 send_req = 1'b1;
    saw_busy = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy) saw_busy = 1;
      if (send_req) send_req = 1'b0;
    end
    check("ena_low_no_frame", 64'(saw_busy), 64'd0);
    ena = 1'b1;
    repeat (6) @(posedge clk);

    // Reset in the middle of a frame
    @(posedge clk); #1;
    sweep_all = 1'b0; ch_select = 2'd2; count2 = 20'hC0FFE;
    send_req = 1'b1;
    repeat (4) @(posedge clk);
    #1 send_req = 1'b0;
    repeat (9) @(posedge clk);
    #3 check("busy_before_abort", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_line", 64'(data_stream), 64'(clk));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    do_req(1'b0, 2'd2, 20'h0, 20'h0, 20'hC0FFE, 1'b0, 1'b0);

    // Randomized requests
    for (int k = 0; k < 12; k++) begin
      logic [1:0] rch;
      rch = 2'($urandom_range(0, 3));
      do_req(1'($urandom), rch, CL'($urandom), CL'($urandom), CL'($urandom), 1'b0, 1'b0);
    end

    repeat (4) @(posedge clk);
    check("frames_left", 64'(exp_q.size()), 64'd0);
    check("bursts_left", 64'(burst_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
